// File: rtl/result_monitor.sv
// result_monitor: bus-snooping verdict monitor for 6502 regression benches.
// Watches CPU writes for the result signature and latches a sticky PASS/FAIL
// verdict, with timeout detection and an optional trap-loop detector that is
// built only when the macro TRAP_DETECT_EN is defined.
module result_monitor #(
    parameter logic [15:0] RESULT_ADDR = 16'h022A,
    parameter logic [7:0]  EXPECT      = 8'h55,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned TRAP_COUNT  = 3
) (
    input  logic             ph2,
    input  logic             reset,
    input  logic [15:0]      address,
    input  logic [7:0]       data_out,
    input  logic             memwrite,
    input  logic             sync,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CYC_W-1:0] cycles
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    localparam logic [CYC_W-1:0] LP_TO_LAST = CYC_W'(TIMEOUT - 1);

    state_t r_state;
    logic   w_result_wr;
    logic   w_timeout;
    logic   w_trap;

    assign w_result_wr = memwrite && (address == RESULT_ADDR);
    assign w_timeout   = (cycles == LP_TO_LAST);

`ifdef TRAP_DETECT_EN
    localparam int unsigned CNT_W = $clog2(TRAP_COUNT + 1);

    logic [15:0]      r_last_addr;
    logic [CNT_W-1:0] r_rep_cnt;
    logic             r_valid;
    logic             w_repeat;

    assign w_repeat = sync && r_valid && (address == r_last_addr);
    // The trap fires on the edge where the repeat count steps up to TRAP_COUNT.
    assign w_trap   = w_repeat && (r_rep_cnt == CNT_W'(TRAP_COUNT - 1));

    // Track consecutive opcode fetches from the same address while running.
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_last_addr <= '0;
            r_rep_cnt   <= '0;
            r_valid     <= 1'b0;
        end else if (r_state == ST_RUN && sync) begin
            if (w_repeat) begin
                if (r_rep_cnt != CNT_W'(TRAP_COUNT))
                    r_rep_cnt <= r_rep_cnt + 1'b1;
            end else begin
                r_last_addr <= address;
                r_valid     <= 1'b1;
                r_rep_cnt   <= '0;
            end
        end
    end
`else
    logic w_unused_sync;

    assign w_unused_sync = sync;
    assign w_trap        = 1'b0;
`endif

    // Verdict FSM: result write beats trap, trap beats timeout; terminal states hold.
    always_ff @(posedge ph2) begin
        if (reset) begin
            r_state   <= ST_RUN;
            cycles    <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= 2'b00;
        end else if (r_state == ST_RUN) begin
            cycles <= cycles + 1'b1;
            if (w_result_wr) begin
                done <= 1'b1;
                if (data_out == EXPECT) begin
                    r_state <= ST_PASS;
                    pass    <= 1'b1;
                end else begin
                    r_state   <= ST_FAIL;
                    fail_code <= 2'b01;
                end
            end else if (w_trap) begin
                r_state   <= ST_FAIL;
                done      <= 1'b1;
                fail_code <= 2'b11;
            end else if (w_timeout) begin
                r_state   <= ST_FAIL;
                done      <= 1'b1;
                fail_code <= 2'b10;
            end
        end
    end

endmodule
